// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for R = k*P, driving one shared affine point-op unit.
// Latency: done K_W+1 cycles after start accept, plus (1 + unit latency) per issued add/double.
// Backpressure: start is taken only in IDLE (no queueing); the controller stalls indefinitely on op_done.
module ecc_scalar_mult_ctrl #(
    parameter int K_W = 256,
    parameter int CW  = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K_W-1:0] k,
    input  logic [CW-1:0]  px,
    input  logic [CW-1:0]  py,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  rx,
    output logic [CW-1:0]  ry,
    output logic           r_inf,
    output logic           op_start,
    output logic           op_dbl,
    output logic [CW-1:0]  op_x1,
    output logic [CW-1:0]  op_y1,
    output logic [CW-1:0]  op_x2,
    output logic [CW-1:0]  op_y2,
    input  logic           op_done,
    input  logic [CW-1:0]  op_x3,
    input  logic [CW-1:0]  op_y3,
    output logic [15:0]    op_count
);

    localparam int            IW      = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(K_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT,
        S_DBL_ISSUE,
        S_DBL_WAIT,
        S_ADD_ISSUE,
        S_ADD_WAIT,
        S_FIN
    } state_t;

    state_t         state;
    state_t         state_n;

    // Job context latched at start accept
    logic [K_W-1:0] k_q;
    logic [CW-1:0]  p_x;
    logic [CW-1:0]  p_y;
    logic [IW-1:0]  idx;

    // Running accumulator; acc_inf marks the point at infinity, in which case acc_x/acc_y are meaningless
    logic [CW-1:0]  acc_x;
    logic [CW-1:0]  acc_y;
    logic           acc_inf;

    // Per-cycle control strobes produced by the next-state logic
    logic           accept;
    logic           load_p;
    logic           take_res;
    logic           adv;
    logic           idx_dec;
    logic           ld_dbl;
    logic           ld_add;
    logic           fin;

    assign busy = (state != S_IDLE);

    // State register; reset aborts any job in flight immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and command strobes
    always_comb begin
        state_n  = state;
        op_start = 1'b0;
        accept   = 1'b0;
        load_p   = 1'b0;
        take_res = 1'b0;
        adv      = 1'b0;
        idx_dec  = 1'b0;
        ld_dbl   = 1'b0;
        ld_add   = 1'b0;
        fin      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = S_BIT;
                end
            end
            S_BIT: begin
                if (acc_inf) begin
                    // Doubling infinity is a no-op and adding P to infinity is a plain load,
                    // so nothing is sent to the point-op unit until the first set bit.
                    load_p = k_q[idx];
                    adv    = 1'b1;
                end else begin
                    ld_dbl  = 1'b1;
                    state_n = S_DBL_ISSUE;
                end
            end
            S_DBL_ISSUE: begin
                op_start = 1'b1;
                state_n  = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (op_done) begin
                    take_res = 1'b1;
                    if (k_q[idx]) begin
                        ld_add  = 1'b1;
                        state_n = S_ADD_ISSUE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_ADD_ISSUE: begin
                op_start = 1'b1;
                state_n  = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (op_done) begin
                    take_res = 1'b1;
                    adv      = 1'b1;
                end
            end
            S_FIN: begin
                fin     = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Move to the next lower scalar bit, or finish after bit 0
        if (adv) begin
            if (idx == '0) begin
                state_n = S_FIN;
            end else begin
                idx_dec = 1'b1;
                state_n = S_BIT;
            end
        end
    end

    // Datapath: job context, accumulator, operand registers, result and op counter
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            p_x      <= '0;
            p_y      <= '0;
            idx      <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            acc_inf  <= 1'b1;
            op_dbl   <= 1'b0;
            op_x1    <= '0;
            op_y1    <= '0;
            op_x2    <= '0;
            op_y2    <= '0;
            done     <= 1'b0;
            rx       <= '0;
            ry       <= '0;
            r_inf    <= 1'b1;
            op_count <= '0;
        end else begin
            // done is registered alongside rx/ry so the result is valid in the pulse cycle
            done <= fin;

            if (accept) begin
                k_q      <= k;
                p_x      <= px;
                p_y      <= py;
                idx      <= IDX_TOP;
                acc_inf  <= 1'b1;
                op_count <= '0;
            end

            if (idx_dec) begin
                idx <= idx - IW'(1);
            end

            if (load_p) begin
                acc_x   <= p_x;
                acc_y   <= p_y;
                acc_inf <= 1'b0;
            end

            if (take_res) begin
                acc_x <= op_x3;
                acc_y <= op_y3;
            end

            // Operands are set up one cycle ahead so they are valid with op_start and then held
            if (ld_dbl) begin
                op_dbl <= 1'b1;
                op_x1  <= acc_x;
                op_y1  <= acc_y;
                op_x2  <= acc_x;
                op_y2  <= acc_y;
            end

            // The add follows a double directly, so the fresh result feeds operand 1
            if (ld_add) begin
                op_dbl <= 1'b0;
                op_x1  <= op_x3;
                op_y1  <= op_y3;
                op_x2  <= p_x;
                op_y2  <= p_y;
            end

            if (op_start && (op_count != 16'hFFFF)) begin
                op_count <= op_count + 16'd1;
            end

            if (fin) begin
                rx    <= acc_x;
                ry    <= acc_y;
                r_inf <= acc_inf;
            end
        end
    end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl: stub point-op unit (3-cycle WAIT, x3=x1+x2), result scoreboard.
// Expected results come from k*P arithmetic and the bit pattern of k, not from the controller structure.
// Stimulus drives just after posedge; the monitor samples on negedge.
module tb_ecc_scalar_mult_ctrl;

    localparam int K_W   = 4;
    localparam int CW    = 16;
    localparam int OPLAT = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k;
    logic [CW-1:0]  px, py;
    logic           busy, done, r_inf, op_start, op_dbl, op_done;
    logic [CW-1:0]  rx, ry, op_x1, op_y1, op_x2, op_y2, op_x3, op_y3;
    logic [15:0]    op_count;

    ecc_scalar_mult_ctrl #(.K_W(K_W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k), .px(px), .py(py),
        .busy(busy), .done(done), .rx(rx), .ry(ry), .r_inf(r_inf),
        .op_start(op_start), .op_dbl(op_dbl),
        .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
        .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stub point-op unit: latches operands at op_start, answers OPLAT cycles later, ignores reset
    logic [OPLAT-1:0] pipe = '0;
    logic [CW-1:0]    sx1 = '0, sy1 = '0, sx2 = '0, sy2 = '0;
    logic             inj_done;
    always @(posedge clk) begin
        pipe <= {pipe[OPLAT-2:0], op_start};
        if (op_start) begin
            sx1 <= op_x1; sy1 <= op_y1; sx2 <= op_x2; sy2 <= op_y2;
        end
    end
    assign op_done = pipe[OPLAT-1] | inj_done;
    assign op_x3   = sx1 + sx2;
    assign op_y3   = sy1 + sy2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          inf;
        logic          chk_xy;
        int            cnt;
        int            lat;
    } job_t;

    job_t exp_q[$];
    bit   dbl_q[$];

    // Reference: R = k*P; for bits below the top set bit, each bit costs a double plus an add if set
    task automatic push_job(input logic [K_W-1:0] kk, input logic [CW-1:0] x, input logic [CW-1:0] y,
                            input bit fresh, input bit want_result);
        job_t j;
        int   msb = -1;
        int   pc  = 0;
        int   ops;
        for (int i = 0; i < K_W; i++) begin
            if (kk[i]) begin
                msb = i;
                pc++;
            end
        end
        ops      = (msb < 0) ? 0 : msb + pc - 1;
        j.inf    = (kk == '0);
        j.x      = j.inf ? '0 : CW'(32'(kk) * 32'(x));
        j.y      = j.inf ? '0 : CW'(32'(kk) * 32'(y));
        j.chk_xy = !j.inf || fresh;
        j.cnt    = ops;
        j.lat    = K_W + 1 + ops * (OPLAT + 1);
        for (int i = msb - 1; i >= 0; i--) begin
            dbl_q.push_back(1'b1);
            if (kk[i]) dbl_q.push_back(1'b0);
        end
        if (want_result) exp_q.push_back(j);
    endtask

    // Monitor / scoreboard
    bit            mon_en   = 1'b0;
    int            acc_cyc  = 0;
    logic [CW-1:0] hold_x   = '0;
    logic [CW-1:0] hold_y   = '0;
    logic          hold_inf = 1'b1;
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    job_t j;
                    j = exp_q.pop_front();
                    if (j.chk_xy) begin
                        chk("rx", rx, j.x);
                        chk("ry", ry, j.y);
                    end
                    chk("r_inf", r_inf, j.inf);
                    chk("op_count", op_count, j.cnt);
                    chk("latency", cyc - acc_cyc, j.lat);
                    hold_x   = j.chk_xy ? j.x : rx;
                    hold_y   = j.chk_xy ? j.y : ry;
                    hold_inf = j.inf;
                end
            end else begin
                chk("result_hold", {rx, ry, r_inf}, {hold_x, hold_y, hold_inf});
            end
            if (op_start) begin
                if (dbl_q.size() == 0) begin
                    chk("unexpected_op_start", 1, 0);
                end else begin
                    chk("op_dbl", op_dbl, dbl_q.pop_front());
                end
            end
            if (pipe[OPLAT-1] && busy) begin
                chk("operands_stable", {op_x1, op_y1, op_x2, op_y2}, {sx1, sy1, sx2, sy2});
            end
            if (start && !busy && !rst) acc_cyc = cyc + 1;
            if (rst) begin
                hold_x   = '0;
                hold_y   = '0;
                hold_inf = 1'b1;
            end
        end
    end

    task automatic wait_empty();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            chk("job_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_job(input logic [K_W-1:0] kk, input logic [CW-1:0] x, input logic [CW-1:0] y,
                           input bit fresh);
        k  = kk;
        px = x;
        py = y;
        push_job(kk, x, y, fresh, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_empty();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nops;
        rst = 1'b1; start = 1'b0; k = '0; px = '0; py = '0; inj_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_op_start", op_start, 0);
        chk("reset_op_dbl", op_dbl, 0);
        chk("reset_rxry", {rx, ry}, 0);
        chk("reset_r_inf", r_inf, 1);
        chk("reset_op_count", op_count, 0);
        chk("reset_operands", {op_x1, op_y1, op_x2, op_y2}, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Zero scalar, single low bit, mixed pattern
        run_job(4'b0000, 16'd1, 16'd100, 1'b1);
        run_job(4'b0001, 16'd1, 16'd100, 1'b0);
        run_job(4'b1011, 16'd1, 16'd100, 1'b0);

        // start held high across a whole job; spurious op_done pulses while idle
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        k = 4'b1111; px = 16'd1; py = 16'd100;
        push_job(4'b1111, 16'd1, 16'd100, 1'b0, 1'b1);
        push_job(4'b1111, 16'd1, 16'd100, 1'b0, 1'b1);
        start = 1'b1;
        for (int t = 0; t < 300 && exp_q.size() == 2; t++) begin
            @(negedge clk); #2;
        end
        chk("held_first_done", exp_q.size(), 1);
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        chk("restart_busy", busy, 1);
        start = 1'b0;
        wait_empty();

        // Reset during the second double's wait; the stub's answer arrives after reset
        k = 4'b1011; px = 16'd1; py = 16'd100;
        push_job(4'b1011, 16'd1, 16'd100, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nops = 0;
        for (int t = 0; t < 100 && nops < 2; t++) begin
            @(posedge clk); #1;
            if (op_start) nops++;
        end
        chk("abort_reached_2nd_dbl", nops, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dbl_q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_r_inf", r_inf, 1);
        chk("abort_op_count", op_count, 0);
        chk("abort_done", done, 0);
        repeat (4) begin @(posedge clk); #1; end
        run_job(4'b0011, 16'd1, 16'd100, 1'b0);

        // Back-to-back jobs; result must hold between done pulses
        run_job(4'b0010, 16'd1, 16'd100, 1'b0);
        run_job(4'b0100, 16'd1, 16'd100, 1'b0);

        // Randomised jobs
        for (int n = 0; n < 20; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            run_job(K_W'($urandom_range(0, 15)), CW'($urandom_range(0, 2000)),
                    CW'($urandom_range(0, 2000)), 1'b0);
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("op_queue_drained", dbl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
- Left-to-right double-and-add sequencer for ECDSA scalar multiplication R = k*P.
- Drives one shared affine point-operation unit (add/double) through a start/done handshake and tracks the point at infinity internally.
- Sits between the signature FSM (start/done, k, P) and the point-op datapath.

Parameters:
- K_W, 256, scalar width in bits (the bench uses 4).
- CW, 256, coordinate width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- k  in  K_W  scalar; latched on accepted start.
- px, py  in  CW each  base point P; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- rx, ry  out  CW each  result; held until the next done.
- r_inf  out  1  result is the point at infinity.
- op_start  out  1  one-cycle command pulse to the point-op unit.
- op_dbl  out  1  1 = double, 0 = add.
- op_x1, op_y1, op_x2, op_y2  out  CW each  operands.
- op_done  in  1  point-op result valid pulse.
- op_x3, op_y3  in  CW each  point-op result, sampled when op_done=1.
- op_count  out  16  operations issued since the last accepted start.

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE.
  - busy, done, op_start, op_dbl = 0.
  - rx, ry, op_* operands = 0.
  - r_inf = 1, op_count = 0.
  - Internal acc = 0, acc_inf = 1.
  - Reset mid-operation aborts immediately. A late op_done after reset is ignored.
- States: IDLE, BIT, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, FIN.
- IDLE:
  - start=1 latches k, px, py and sets idx=K_W-1, acc_inf=1, op_count=0; next state BIT.
  - start=0 keeps IDLE.
- BIT:
  - acc_inf=1: if k[idx]=1, then acc<=P and acc_inf<=0. No operation is issued. Then advance.
  - acc_inf=0: go to DBL_ISSUE.
  - Exactly one cycle is spent in BIT per visit.
- advance: if idx==0, go to FIN; otherwise idx<=idx-1 and go to BIT.
- DBL_ISSUE (one cycle):
  - op_start=1, op_dbl=1, (x1,y1)=(x2,y2)=acc.
  - op_count increments.
  - Next state DBL_WAIT.
- DBL_WAIT:
  - Operands are held stable and op_dbl=1.
  - On op_done: acc<=(op_x3,op_y3). Then go to ADD_ISSUE if k[idx]=1, otherwise advance.
  - The controller waits indefinitely; there is no timeout.
- ADD_ISSUE (one cycle):
  - op_start=1, op_dbl=0, (x1,y1)=acc, (x2,y2)=P.
  - op_count increments.
  - Next state ADD_WAIT.
- ADD_WAIT:
  - Operands are held stable.
  - On op_done: acc<=result, then advance.
- FIN:
  - done=1 for one cycle; rx,ry<=acc and r_inf<=acc_inf (registered so they are valid in the same cycle done=1).
  - Next state IDLE.
- Operand hold: op_dbl and the operands keep their last values outside ISSUE/WAIT. Only op_start is qualified.
- Ignored inputs:
  - op_done in IDLE, BIT, ISSUE or FIN is ignored. The unit must not respond in the issue cycle.
  - start while busy is ignored; there is no queueing.
- The controller never issues an add or double involving infinity. The add with acc_inf=1 is replaced by a load, and no double is issued while acc_inf=1.
  - The point-op unit still sees P+P for k such that acc==P at an add. Exceptional-case handling (P+P, P+(-P)) is the point-op unit's responsibility.
- Latency:
  - k=0: done is high exactly K_W+1 cycles after the start-accept edge.
  - General: done asserts K_W+1 + sum over issued operations of (1 + unit latency) cycles after start-accept, where unit latency = number of WAIT cycles up to and including the op_done cycle.
- op_count saturates at 16'hFFFF.

Test Plan:
- K_W=4. Stub point-op unit: op_done 3 cycles after op_start (WAIT length 3); x3=x1+x2, y3=y1+y2 (double = 2x). P=(1,100).
- k=4'b0000 -> no op_start ever; done exactly 5 cycles after start-accept; r_inf=1, rx=ry=0, op_count=0.
- k=4'b0001 -> no op_start; done 5 cycles after start-accept; r_inf=0, (rx,ry)=(1,100).
- k=4'b1011 -> op sequence DBL,DBL,ADD,DBL,ADD (op_dbl=1,1,0,1,0); (rx,ry)=(11,1100); op_count=5; done at cycle 5+5*4=25; operands stable through each WAIT.
- k=4'b1111 with start held high for the whole run, and an extra op_done pulse injected in IDLE -> one job only; result (15,1500), op_count=6; spurious op_done does not corrupt acc; a second job starts the cycle after return to IDLE.
- rst=1 pulsed during the 2nd DBL_WAIT of k=4'b1011, with the stub's op_done arriving afterwards -> next cycle IDLE, busy=0, r_inf=1, op_count=0, no done; late op_done ignored; a fresh k=4'b0011 job yields (3,300).
- Back-to-back jobs k=4'b0010 then k=4'b0100 -> results (2,200) then (4,400); rx/ry hold (2,200) between the done pulses.
